// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared constants and fetch entry layout for the CPU5 fetch path
//
// Purpose: instruction width, default reset PC and the {pc, instr} entry
//          carried through the fetch buffer.
// Ports  : none (package).
`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif

package ifetch_unit_pkg;

   localparam int INSTR_W = 32;

   // Byte address the PC takes on reset.
   localparam int unsigned CPU5_RESET_PC = 0;

   // One buffered fetch: the byte address and the instruction fetched from it.
   typedef struct packed {
      logic [`CPU5_XLEN-1:0] pc;
      logic [INSTR_W-1:0]    instr;
   } fetch_entry_t;

   localparam int ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifetch_fifo.sv
// rtl/ifetch_fifo.sv - 2-entry fetch buffer with push/pop/flush
//
// Purpose: small in-order buffer between the instruction memory and decode.
// Ports  : clk, reset (async, active-high)
//          push/pop/flush  - control; flush wins over push
//          din             - entry written at the tail on push
//          count           - occupied entries (0..2)
//          head            - oldest entry; holds its last value while empty
module ifetch_fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [1:0]   count,
   output logic [W-1:0] head
);
   import ifetch_unit_pkg::*;

   logic [W-1:0] second;
   logic         pop_ok;
   logic         push_ok;

   // Guard against a pop on empty and a push into a full buffer without a pop.
   assign pop_ok  = pop & (count != 2'd0);
   assign push_ok = push & ((count != 2'(DEPTH)) | pop_ok);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count  <= 2'd0;
         head   <= '0;
         second <= '0;
      end else if (flush) begin
         // Contents are left alone so the head outputs hold their last value.
         count <= 2'd0;
      end else begin
         if (pop_ok && count == 2'd2)
            head <= second;
         if (push_ok) begin
            // New entry lands at the head when it would be the only occupant.
            if (count == 2'd0 || (count == 2'd1 && pop_ok))
               head <= din;
            else
               second <= din;
         end
         count <= count + 2'(push_ok) - 2'(pop_ok);
      end
   end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - CPU5 instruction-fetch initiator
//
// Purpose: holds the fetch PC, reads the word-indexed instruction memory,
//          buffers two instructions and hands them to decode over valid/ready.
// Ports  : clk, reset (async, active-high)
//          icache_a/icache_q           - combinational instruction-memory port
//          redirect_valid/redirect_pc  - branch/jump redirect, flushes buffer
//          fetch_valid/fetch_instr/fetch_pc/fetch_ready - decode handshake
//          perf_fetched/perf_stall     - only with CPU5_IFETCH_PERF_EN defined
`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif

module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter int          XLEN     = `CPU5_XLEN,
   parameter int          IA_W     = 8,
   parameter int unsigned RESET_PC = CPU5_RESET_PC,
   parameter int          DEPTH    = 2
) (
   input  logic               clk,
   input  logic               reset,
   output logic [IA_W-1:0]    icache_a,
   input  logic [XLEN-1:0]    icache_q,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               fetch_valid,
   output logic [INSTR_W-1:0] fetch_instr,
   output logic [XLEN-1:0]    fetch_pc,
   input  logic               fetch_ready
`ifdef CPU5_IFETCH_PERF_EN
   ,
   output logic [31:0]        perf_fetched,
   output logic [31:0]        perf_stall
`endif
);

   logic [XLEN-1:0] pc;
   logic [1:0]      count;
   logic            pop;
   logic            push;
   fetch_entry_t    tail_entry;
   fetch_entry_t    head_entry;

   assign icache_a = pc[IA_W+1:2];

   assign fetch_valid = (count != 2'd0);
   assign pop         = fetch_valid & fetch_ready;
   assign push        = ~redirect_valid & ((count < 2'd2) | pop);

   assign tail_entry.pc    = pc;
   assign tail_entry.instr = icache_q[INSTR_W-1:0];

   ifetch_fifo #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (tail_entry),
      .count (count),
      .head  (head_entry)
   );

   assign fetch_pc    = head_entry.pc;
   assign fetch_instr = head_entry.instr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         pc <= XLEN'(RESET_PC);
      else if (redirect_valid)
         pc <= redirect_pc & ~XLEN'(3);   // targets are word aligned
      else if (push)
         pc <= pc + XLEN'(4);             // wraps modulo 2^XLEN
   end

`ifdef CPU5_IFETCH_PERF_EN
   // Saturating event counters; redirects do not clear them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched <= '0;
         perf_stall   <= '0;
      end else begin
         if (push && perf_fetched != 32'hFFFF_FFFF)
            perf_fetched <= perf_fetched + 32'd1;
         if (fetch_valid && !fetch_ready && perf_stall != 32'hFFFF_FFFF)
            perf_stall <= perf_stall + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - scoreboard bench for ifetch_unit
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  icache_a;
   logic [31:0] icache_q;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        fetch_valid;
   logic [31:0] fetch_instr;
   logic [31:0] fetch_pc;
   logic        fetch_ready = 1'b0;
`ifdef CPU5_IFETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   int checks   = 0;
   int failures = 0;

   // Reference model: the ordered stream of PCs decode should see, and
   // whether the head is expected to be valid this cycle.
   logic [31:0] exp_q[$];
   logic [31:0] gen_pc;
   logic        exp_valid = 1'b0;
   logic        mon_en = 1'b0;

   always #5 clk = ~clk;

   // Instruction memory: word i holds 0x1000_0000 + i.
   assign icache_q = 32'h1000_0000 + {24'h0, icache_a};

   ifetch_unit #(
      .XLEN     (32),
      .IA_W     (8),
      .RESET_PC (0),
      .DEPTH    (2)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .icache_a       (icache_a),
      .icache_q       (icache_q),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_valid    (fetch_valid),
      .fetch_instr    (fetch_instr),
      .fetch_pc       (fetch_pc),
      .fetch_ready    (fetch_ready)
`ifdef CPU5_IFETCH_PERF_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_stall     (perf_stall)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return 32'h1000_0000 + ((addr >> 2) & 32'hFF);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic refill();
      while (exp_q.size() < 4) begin
         exp_q.push_back(gen_pc);
         gen_pc = gen_pc + 32'd4;
      end
   endtask

   task automatic model_restart(input logic [31:0] start);
      exp_q.delete();
      gen_pc = start & ~32'd3;
      refill();
   endtask

   // One clock cycle of stimulus; model updated just after the edge.
   task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt);
      fetch_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = tgt;
      @(posedge clk);
      #1;
      if (rv) begin
         model_restart(tgt);
         exp_valid = 1'b0;
      end else begin
         exp_valid = 1'b1;
      end
      refill();
   endtask

   // Monitor: head must always be the front of the expected stream.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("fetch_valid", {31'h0, fetch_valid}, {31'h0, exp_valid});
         if (fetch_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL queue_empty actual=%h expected=none", fetch_pc);
            end else begin
               chk("fetch_pc", fetch_pc, exp_q[0]);
               chk("fetch_instr", fetch_instr, mem_word(exp_q[0]));
               if (fetch_ready)
                  void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [31:0] tgt;
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'h0, fetch_valid}, 32'h0);
      chk("rst_instr", fetch_instr, 32'h0);
      chk("rst_pc", fetch_pc, 32'h0);
      chk("rst_icache_a", {24'h0, icache_a}, 32'h0);
      reset = 1'b0;
      model_restart(32'h0);
      exp_valid = 1'b0;
      mon_en = 1'b1;

      // Stream, then backpressure on the pc=8 head
      repeat (3) step(1'b1, 1'b0, 32'h0);
      repeat (5) step(1'b0, 1'b0, 32'h0);
      chk("bp_icache_a", {24'h0, icache_a}, 32'h4);
      chk("bp_head_pc", fetch_pc, 32'h8);
      repeat (4) step(1'b1, 1'b0, 32'h0);

      // Redirect while full
      repeat (2) step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'h0000_0103);
      step(1'b1, 1'b0, 32'h0);
      chk("redir_pc", fetch_pc, 32'h100);
      chk("redir_instr", fetch_instr, 32'h1000_0040);
      repeat (4) step(1'b1, 1'b0, 32'h0);

      // Index wrap
      step(1'b1, 1'b1, 32'h3FC);
      step(1'b1, 1'b0, 32'h0);
      chk("wrap_icache_a", {24'h0, icache_a}, 32'h0);
      chk("wrap_instr", fetch_instr, 32'h1000_00FF);
      repeat (3) step(1'b1, 1'b0, 32'h0);

      // Randomized traffic, including targets near the top of the address space
      for (int i = 0; i < 400; i++) begin
         logic rv;
         rv = ($urandom % 16) == 0;
         case ($urandom % 3)
            0:       tgt = $urandom & 32'h3FF;
            1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            default: tgt = $urandom;
         endcase
         step(($urandom % 4) != 0, rv, tgt);
      end

      // Asynchronous reset pulse away from a clock edge
      step(1'b1, 1'b0, 32'h0);
      #3;
      mon_en = 1'b0;
      reset = 1'b1;
      #1;
      chk("arst_valid", {31'h0, fetch_valid}, 32'h0);
      chk("arst_instr", fetch_instr, 32'h0);
      chk("arst_pc", fetch_pc, 32'h0);
      chk("arst_icache_a", {24'h0, icache_a}, 32'h0);
      #2;
      reset = 1'b0;
      model_restart(32'h0);
      exp_valid = 1'b0;
      mon_en = 1'b1;

      // 10 fetches with 3 stall cycles
      repeat (7) step(1'b1, 1'b0, 32'h0);
      repeat (3) step(1'b0, 1'b0, 32'h0);
      repeat (2) step(1'b1, 1'b0, 32'h0);
`ifdef CPU5_IFETCH_PERF_EN
      chk("perf_fetched", perf_fetched, 32'd10);
      chk("perf_stall", perf_stall, 32'd3);
`endif
      repeat (4) step(1'b1, 1'b0, 32'h0);
      mon_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction-fetch initiator for the CPU5 core; drives the word-indexed combinational instruction-memory port (8-bit index in, `CPU5_XLEN` word out).
- Holds the fetch PC and captures instruction words into a 2-entry buffer.
- Presents instructions to decode over a valid/ready handshake; supports PC redirect from branch/jump resolution.

Parameters:
- XLEN, `CPU5_XLEN, datapath/PC width.
- IA_W, 8, instruction-memory index width.
- RESET_PC, 0, byte address loaded into the PC on reset.
- DEPTH, 2, buffer entries (fixed at 2; parameter exists for the sub-module only).

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- icache_a  out  IA_W  memory word index, = pc[IA_W+1:2].
- icache_q  in  XLEN  memory word; instruction is icache_q[31:0], same cycle as icache_a.
- redirect_valid  in  1  load new PC, flush buffer.
- redirect_pc  in  XLEN  redirect target (byte address, bits [1:0] ignored, treated as 0).
- fetch_valid  out  1  buffer head holds an instruction.
- fetch_instr  out  32  head instruction.
- fetch_pc  out  XLEN  head instruction byte address.
- fetch_ready  in  1  decode accepts head this cycle.

Behaviour:
- Reset (async): pc=RESET_PC, buffer count=0, fetch_valid=0, fetch_instr=0, fetch_pc=0; icache_a = RESET_PC[IA_W+1:2].
- icache_a is driven combinationally from the pc register.
- pop = fetch_valid & fetch_ready.
- push = !redirect_valid & (count<2 | pop).
- On push: the entry {pc, icache_q[31:0]} enters the tail, and pc <= pc+4.
- Latency: first instruction is valid in the cycle after reset deassertion; 1 cycle from redirect to fetch_valid.
- Throughput: sustained one instruction per cycle while fetch_ready=1.
- Buffer full (count=2) and no pop: no fetch; pc holds; head stable.
- Full with pop: simultaneous pop and push; count stays 2.
- Empty: fetch_valid=0; fetch_instr/fetch_pc hold their last values (0 after reset). Don't-care for decode.
- Redirect:
  - Buffer is cleared (count=0) on the next edge, regardless of fetch_ready.
  - pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - No push that cycle.
  - A handshake on the head in the same cycle still counts as consumed by decode.
- PC wrap: pc+4 wraps modulo 2^XLEN. The index wraps 255->0 naturally (pc[IA_W+1:2]); no fault is raised.
- Handshake rule: while fetch_valid=1 and fetch_ready=0, fetch_instr/fetch_pc are stable until a pop or a redirect occurs.
- Reset asserted mid-stream discards all entries immediately (async); outputs return to reset values.

Optional Feature:
- Macro: CPU5_IFETCH_PERF_EN.
- Defined: adds outputs perf_fetched (32, count of pushes) and perf_stall (32, cycles with fetch_valid&!fetch_ready).
  - Both saturate at 0xFFFFFFFF and reset to 0.
  - A redirect does not clear either counter.
- Undefined: both ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared defines/package: CPU5_XLEN, INSTR_W=32, the reset-PC constant, and the fetch entry layout {pc, instr}.
- Sub-module ifetch_fifo:
  - 2-entry synchronous buffer with push/pop/flush, count, and head outputs.
  - Flush has priority over push.
  - Async active-high reset on clk.

Test Plan:
- Memory word i = 0x1000_0000+i; RESET_PC=0; fetch_ready=1 after reset.
  - fetch_valid=1 the cycle after reset deassertion.
  - fetch_pc sequence is 0,4,8,…; fetch_instr sequence is 0x10000000, 0x10000001, …
- Backpressure: ready=0 for 5 cycles from the pc=8 head.
  - Head stays pc=8 / 0x10000002.
  - count=2; icache_a holds 4.
  - On release, pc 8,12,16 follow with no gap or duplicate.
- Redirect to 0x0000_0103 while the buffer is full.
  - Next cycle fetch_valid=0.
  - Following cycle fetch_pc=0x100, fetch_instr=0x10000040.
- Wrap: redirect to 0x3FC.
  - Sequence 0x3FC (instr 0x100000FF) then 0x400, with icache_a=0 and instr 0x10000000.
- Async reset pulse mid-stream (not on a clock edge): outputs return to 0 immediately; the fetch restarts at RESET_PC.
- PERF_EN build: 10 fetches with 3 stall cycles → perf_fetched=10, perf_stall=3.
